axis_arbiter: RTL and testbench
===============================

# axis_arbiter

Packet-aware N:1 round-robin arbiter/multiplexer for AXI-Stream, placed directly upstream of `axis_register` in the switch output path. It selects one of `N_PORTS` slave streams, holds the grant for a whole packet (up to and including the `last` beat), and presents that stream on a single master port. Its master side is a combinational pass-through of the granted input, so `axis_register` downstream breaks the timing path.

## Interface
- `N_PORTS`, 4: number of slave inputs, ≥1.
- `T_DATA_WIDTH`, 17: data width per beat.
- `T_ID_WIDTH`, 10: id width per beat.
- `T_USER_WIDTH`, 19: user width per beat.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `s_id_i`  in  `N_PORTS*T_ID_WIDTH`  packed ids, port k at `[k*T_ID_WIDTH +: T_ID_WIDTH]`.
- `s_data_i`  in  `N_PORTS*T_DATA_WIDTH`  packed data, same packing.
- `s_user_i`  in  `N_PORTS*T_USER_WIDTH`  packed user, same packing.
- `s_last_i`  in  `N_PORTS`  end-of-packet per port.
- `s_valid_i`  in  `N_PORTS`  valid per port.
- `s_ready_o`  out  `N_PORTS`  ready per port.
- `m_id_o`  out  `T_ID_WIDTH`  granted id.
- `m_data_o`  out  `T_DATA_WIDTH`  granted data.
- `m_user_o`  out  `T_USER_WIDTH`  granted user.
- `m_last_o`  out  1  granted last.
- `m_valid_o`  out  1  granted valid.
- `m_ready_i`  in  1  downstream ready.
- `m_port_o`  out  `PORT_W`  index of the granted port, valid while `m_valid_o`=1.

## Operation
- Two-state FSM, `IDLE` and `LOCK`. Registers: `state`, `grant` (`PORT_W` bits), `last_grant` (`PORT_W` bits).
- **IDLE**
  - All `s_ready_o`=0. `m_valid_o`=0. `m_id/data/user/last/port` = 0.
  - If any `s_valid_i` is set, choose the first valid port scanning `last_grant+1, last_grant+2, …`, wrapping modulo `N_PORTS`.
  - Next cycle: `grant` = chosen port, `last_grant` = chosen port, state = `LOCK`.
- **LOCK**
  - `m_*` = `s_*[grant]`; `m_port_o` = `grant`.
  - `s_ready_o[grant]` = `m_ready_i`; all other ready bits are 0.
  - A handshake (`m_valid_o & m_ready_i`) with `m_last_o`=1 returns the FSM to `IDLE` next cycle.
  - `s_valid_i[grant]` dropping mid-packet does not release the grant; `LOCK` persists until the last beat.
- Arbitration is fair: a port granted in one round has lowest priority in the next.
- `N_PORTS`=1: `PORT_W` forced to 1, `m_port_o`=0; the FSM still runs.
- No data is stored or altered; the block only selects and gates.

## Timing
- Reset (`reset_n`=0 at a rising edge):
  - `state`=`IDLE`, `grant`=0, `last_grant`=`N_PORTS-1`, so port 0 has first priority.
  - All outputs are therefore 0 from the first edge with reset asserted.
- Arbitration latency: 1 cycle. A valid seen in `IDLE` at cycle t gives `m_valid_o`=1 at cycle t+1.
- In `LOCK` the path is 0-latency combinational, valid→valid and ready→ready.
- Packet gap: exactly 1 `IDLE` bubble cycle after every `last` handshake, including single-beat packets. Throughput is at most L/(L+1) for L-beat packets.
- Simultaneous valid requests are resolved in the same `IDLE` cycle by the round-robin order; losers keep their valid asserted and wait.
- Reset mid-packet aborts the packet: the grant is released and no recovery is attempted. Upstream sources are reset by the same `reset_n`.
- `m_ready_i`=0 while locked stalls only the granted port; `s_ready_o[grant]`=0 in that cycle.

## Structure
- `axis_switch_pkg`:
  - `PORT_W` as a function, `$clog2(N_PORTS)` with a minimum of 1.
  - FSM state enum `arb_state_t {IDLE, LOCK}`.
- Sub-module `rr_priority_encoder`: combinational. Inputs are the request vector and `last_grant`; outputs are `found` and `index`. Reusable by the other switch arbiters.

## Test plan
- Reset then single request: port 2 sends a 3-beat packet, data 0x11, 0x12, 0x13, with `m_ready_i`=1 → `m_valid_o` rises 1 cycle after `s_valid_i[2]`. Output data is 0x11, 0x12, 0x13; `m_port_o`=2; `m_last_o` is set on 0x13; `IDLE` follows for 1 cycle.
- All 4 ports valid continuously with 1-beat packets → grant order 0,1,2,3,0,… One beat every 2 cycles.
- Port 1 sends a 4-beat packet while port 0 raises valid at beat 2 → all 4 beats of port 1 complete uninterrupted; port 0 is granted next; `s_ready_o[0]`=0 throughout port 1's packet.
- Backpressure: `m_ready_i` toggles 1,0,1,0 during port 3's packet → each beat is transferred only when `m_ready_i`=1, with no duplication or loss. Data, id, user and last match the input beat for beat.
- Source valid gap: port 0 drops valid for 3 cycles mid-packet while port 1 is valid → the grant stays on port 0 until its last beat.
- Reset mid-packet: `reset_n`=0 on beat 2 of a 5-beat packet → the next cycle shows all outputs 0, the FSM in `IDLE`, and `last_grant`=`N_PORTS-1`.

Source files
------------

// File: rtl/axis_switch_pkg.sv
// Shared types and helpers for the AXI-Stream switch arbiters.
package axis_switch_pkg;

    // Arbiter FSM: waiting for a request, or locked onto one packet.
    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Width of a port index; never below 1 so a single-port switch still
    // has a legal index signal.
    function automatic int port_w(input int n_ports);
        return (n_ports > 1) ? $clog2(n_ports) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Round-robin priority encoder: picks the first set request scanning
// upward from the port after last_grant_i, wrapping around.
module rr_priority_encoder #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic             found_o,
    output logic [IDX_W-1:0] index_o
);

    // cand[k] is the port examined at scan position k (k = 0 is highest priority).
    logic [IDX_W-1:0] cand [N_REQ];
    logic [N_REQ-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign cand[gi] = IDX_W'((32'(last_grant_i) + 32'(gi) + 32'd1) % 32'(N_REQ));
            assign hit[gi]  = req_i[cand[gi]];
        end
    endgenerate

    // Lowest scan position with a pending request wins.
    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                found_o = 1'b1;
                index_o = cand[i];
            end
        end
    end

endmodule

// File: rtl/axis_arbiter.sv
// Packet-aware N:1 round-robin AXI-Stream arbiter. The grant is held for a
// whole packet; the master side is a combinational pass-through of the
// granted slave, with one idle bubble cycle between packets.
module axis_arbiter
    import axis_switch_pkg::*;
#(
    parameter int N_PORTS      = 4,
    parameter int T_DATA_WIDTH = 17,
    parameter int T_ID_WIDTH   = 10,
    parameter int T_USER_WIDTH = 19,
    localparam int PORT_W      = port_w(N_PORTS)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [N_PORTS*T_ID_WIDTH-1:0]   s_id_i,
    input  logic [N_PORTS*T_DATA_WIDTH-1:0] s_data_i,
    input  logic [N_PORTS*T_USER_WIDTH-1:0] s_user_i,
    input  logic [N_PORTS-1:0]              s_last_i,
    input  logic [N_PORTS-1:0]              s_valid_i,
    output logic [N_PORTS-1:0]              s_ready_o,
    output logic [T_ID_WIDTH-1:0]           m_id_o,
    output logic [T_DATA_WIDTH-1:0]         m_data_o,
    output logic [T_USER_WIDTH-1:0]         m_user_o,
    output logic                            m_last_o,
    output logic                            m_valid_o,
    input  logic                            m_ready_i,
    output logic [PORT_W-1:0]               m_port_o
);

    arb_state_t        state_q, state_d;
    logic [PORT_W-1:0] grant_q, grant_d;
    logic [PORT_W-1:0] last_grant_q, last_grant_d;

    logic              rr_found;
    logic [PORT_W-1:0] rr_index;
    logic              last_handshake;

    // Unpacked views of the flattened slave buses.
    logic [T_ID_WIDTH-1:0]   s_id_arr   [N_PORTS];
    logic [T_DATA_WIDTH-1:0] s_data_arr [N_PORTS];
    logic [T_USER_WIDTH-1:0] s_user_arr [N_PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_unpack
            assign s_id_arr[gi]   = s_id_i[gi*T_ID_WIDTH +: T_ID_WIDTH];
            assign s_data_arr[gi] = s_data_i[gi*T_DATA_WIDTH +: T_DATA_WIDTH];
            assign s_user_arr[gi] = s_user_i[gi*T_USER_WIDTH +: T_USER_WIDTH];
        end
    endgenerate

    rr_priority_encoder #(
        .N_REQ (N_PORTS),
        .IDX_W (PORT_W)
    ) u_rr_enc (
        .req_i        (s_valid_i),
        .last_grant_i (last_grant_q),
        .found_o      (rr_found),
        .index_o      (rr_index)
    );

    // Master mux and ready steering; everything is gated to zero while idle.
    always_comb begin
        m_id_o    = '0;
        m_data_o  = '0;
        m_user_o  = '0;
        m_last_o  = 1'b0;
        m_valid_o = 1'b0;
        m_port_o  = '0;
        s_ready_o = '0;
        if (state_q == LOCK) begin
            m_id_o              = s_id_arr[grant_q];
            m_data_o            = s_data_arr[grant_q];
            m_user_o            = s_user_arr[grant_q];
            m_last_o            = s_last_i[grant_q];
            m_valid_o           = s_valid_i[grant_q];
            m_port_o            = grant_q;
            s_ready_o[grant_q]  = m_ready_i;
        end
    end

    assign last_handshake = m_valid_o & m_ready_i & m_last_o;

    // Next-state: grab the round-robin winner when idle, release after the last beat.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    state_d      = LOCK;
                    grant_d      = rr_index;
                    last_grant_d = rr_index;
                end
            end
            LOCK: begin
                if (last_handshake) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset leaves port 0 with first priority.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= PORT_W'(N_PORTS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_axis_arbiter.sv
// Randomized scoreboard bench for axis_arbiter with a packet-level reference model.
module tb_axis_arbiter;

    localparam int NP = 4;
    localparam int DW = 17;
    localparam int IW = 10;
    localparam int UW = 19;
    localparam int PW = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic [UW-1:0] user;
        logic          last;
        int            port;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NP*IW-1:0]  s_id;
    logic [NP*DW-1:0]  s_data;
    logic [NP*UW-1:0]  s_user;
    logic [NP-1:0]     s_last;
    logic [NP-1:0]     s_valid;
    logic [NP-1:0]     s_ready;
    logic [IW-1:0]     m_id;
    logic [DW-1:0]     m_data;
    logic [UW-1:0]     m_user;
    logic              m_last;
    logic              m_valid;
    logic              m_ready;
    logic [PW-1:0]     m_port;

    beat_t pq [NP][$];   // per-source packets still to be sent
    beat_t exp_q [$];    // scoreboard of expected master beats

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: arbiter either free or serving one packet of one port.
    bit mdl_locked = 1'b0;
    int mdl_grant  = 0;
    int mdl_last   = NP - 1;

    bit gen_en, one_beat, drain, did_rst;
    int vprob, rprob;

    axis_arbiter #(
        .N_PORTS      (NP),
        .T_DATA_WIDTH (DW),
        .T_ID_WIDTH   (IW),
        .T_USER_WIDTH (UW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_id_i    (s_id),
        .s_data_i  (s_data),
        .s_user_i  (s_user),
        .s_last_i  (s_last),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .m_id_o    (m_id),
        .m_data_o  (m_data),
        .m_user_o  (m_user),
        .m_last_o  (m_last),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_port_o  (m_port)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Refill empty sources and drive this cycle's slave inputs and m_ready.
    task automatic drive_cycle();
        beat_t b;
        int    len;
        for (int k = 0; k < NP; k++) begin
            if (gen_en && pq[k].size() == 0 && (one_beat || $urandom_range(99) < 40)) begin
                len = one_beat ? 1 : int'($urandom_range(1, 5));
                for (int j = 0; j < len; j++) begin
                    b.data = DW'($urandom);
                    b.id   = IW'($urandom);
                    b.user = UW'($urandom);
                    b.last = (j == len - 1);
                    b.port = k;
                    pq[k].push_back(b);
                end
            end
        end
        for (int k = 0; k < NP; k++) begin
            if (pq[k].size() > 0 && (drain || $urandom_range(99) < vprob)) begin
                s_valid[k]          = 1'b1;
                s_data[k*DW +: DW]  = pq[k][0].data;
                s_id[k*IW +: IW]    = pq[k][0].id;
                s_user[k*UW +: UW]  = pq[k][0].user;
                s_last[k]           = pq[k][0].last;
            end else begin
                s_valid[k]          = 1'b0;
                s_data[k*DW +: DW]  = DW'($urandom);
                s_id[k*IW +: IW]    = IW'($urandom);
                s_user[k*UW +: UW]  = UW'($urandom);
                s_last[k]           = 1'($urandom);
            end
        end
        m_ready = drain || ($urandom_range(99) < rprob);
    endtask

    // Model: per-cycle expectations for valid/ready, then arbitration decisions.
    initial begin : model_proc
        logic          exp_v;
        logic [NP-1:0] exp_r;
        int            pick;
        beat_t         b;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mdl_locked = 1'b0;
                mdl_grant  = 0;
                mdl_last   = NP - 1;
                exp_q.delete();
                for (int k = 0; k < NP; k++) pq[k].delete();
            end else begin
                exp_v = mdl_locked ? s_valid[mdl_grant] : 1'b0;
                exp_r = '0;
                if (mdl_locked && m_ready) exp_r[mdl_grant] = 1'b1;
                check("m_valid", 64'(m_valid), 64'(exp_v));
                check("s_ready", 64'(s_ready), 64'(exp_r));
                if (!mdl_locked)
                    check("idle_outputs_zero", 64'({m_data, m_id, m_user, m_last, m_port}), 64'd0);

                if (!mdl_locked) begin
                    pick = -1;
                    for (int i = 1; i <= NP; i++)
                        if (pick < 0 && s_valid[(mdl_last + i) % NP]) pick = (mdl_last + i) % NP;
                    if (pick >= 0) begin
                        for (int j = 0; j < pq[pick].size(); j++) begin
                            b = pq[pick][j];
                            b.port = pick;
                            exp_q.push_back(b);
                            if (b.last) break;
                        end
                        mdl_locked = 1'b1;
                        mdl_grant  = pick;
                        mdl_last   = pick;
                    end
                end else if (s_valid[mdl_grant] && m_ready && pq[mdl_grant].size() > 0
                             && pq[mdl_grant][0].last) begin
                    mdl_locked = 1'b0;
                end

                for (int k = 0; k < NP; k++)
                    if (s_valid[k] && s_ready[k] && pq[k].size() > 0) void'(pq[k].pop_front());
            end
        end
    end

    // Monitor: every master handshake is matched against the scoreboard.
    initial begin : monitor_proc
        beat_t e;
        forever begin
            @(negedge clk);
            if (reset_n && m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    $display("beat port=%0d data=%h id=%h user=%h last=%b", m_port, m_data, m_id, m_user, m_last);
                    check("m_data", 64'(m_data), 64'(e.data));
                    check("m_id",   64'(m_id),   64'(e.id));
                    check("m_user", 64'(m_user), 64'(e.user));
                    check("m_last", 64'(m_last), 64'(e.last));
                    check("m_port", 64'(m_port), 64'(e.port));
                end
            end
        end
    end

    // Stimulus: reset, round-robin saturation, random traffic with a mid-packet reset, drain.
    initial begin : stim_proc
        int leftover;
        reset_n  = 1'b0;
        gen_en   = 1'b0;
        one_beat = 1'b0;
        drain    = 1'b0;
        did_rst  = 1'b0;
        vprob    = 100;
        rprob    = 100;
        s_valid  = '1;
        s_last   = '1;
        s_data   = '1;
        s_id     = '1;
        s_user   = '1;
        m_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs_zero",
              64'({m_valid, s_ready, m_data, m_id, m_user, m_last, m_port}), 64'd0);

        reset_n = 1'b1;
        gen_en  = 1'b1;
        for (int cyc = 0; cyc < 3500; cyc++) begin
            if (cyc < 200) begin
                one_beat = 1'b1; vprob = 100; rprob = 100;
            end else if (cyc < 1800) begin
                one_beat = 1'b0; vprob = 70;  rprob = 70;
            end else begin
                one_beat = 1'b0; vprob = 90;  rprob = 50;
            end
            reset_n = 1'b1;
            drive_cycle();
            if (cyc >= 1500 && !did_rst && mdl_locked) begin
                reset_n = 1'b0;
                m_ready = 1'b0;
                did_rst = 1'b1;
            end
            @(posedge clk);
            #1;
        end

        reset_n = 1'b1;
        gen_en  = 1'b0;
        drain   = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            drive_cycle();
            @(posedge clk);
            #1;
        end

        leftover = 0;
        for (int k = 0; k < NP; k++) leftover += pq[k].size();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("sources_drained", 64'(leftover), 64'd0);
        check("midpacket_reset_applied", 64'(did_rst), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
